// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// The PARITY state is only reached when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // 3-bit FSM state encoding, exposed on the debug port of fifo_uart_tx
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // UART line levels
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between a first-word-fall-through FIFO and its drain stage.
//
// Handshake: fifo_data is valid whenever fifo_empty=0. The reader pops by raising
// fifo_r_en for exactly one cycle; the word presented in that cycle is consumed on
// the same rising edge, and the FIFO presents its next head word after that edge.
// fifo_r_en is never raised while fifo_empty=1.
interface fifo_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_r_en;

  // drain stage (reader)
  modport master (input fifo_empty, input fifo_data, output fifo_r_en);
  // FIFO (storage side)
  modport slave  (output fifo_empty, output fifo_data, input fifo_r_en);
endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// Held at zero while clear is high so the first bit of a frame is always full length.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = !clear && (cnt_q == LAST);

  // wrap on every bit boundary, hold at zero while cleared
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FWFT FIFO one byte at a time onto an 8N1 UART line, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_uart_tx_if.master         fifo,
  output logic                   tx,
  output logic                   busy,
  output uart_state_e            state_o
);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 pop;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // baud timer only runs while a frame is on the line
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == ST_IDLE),
    .bit_done (bit_done)
  );

  assign fifo.fifo_r_en = pop;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign state_o = state_q;

  // next-state, line level and pop strobe
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        if (!fifo.fifo_empty && !reset) begin
          pop       = 1'b1;
          shift_d   = fifo.fifo_data;
          tx_d      = LINE_START;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo.fifo_data;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = LINE_IDLE;
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          tx_d    = LINE_IDLE;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO feeds the DUT, and each popped byte is
// expanded into its expected per-cycle line waveform from the frame format.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (2 + DB + PAR) * CPB + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_BITS(DB)) fif ();
  logic        tx;
  logic        busy;
  uart_state_e state_dbg;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .fifo    (fif),
    .tx      (tx),
    .busy    (busy),
    .state_o (state_dbg)
  );

  // bench state
  logic [DB-1:0] fifo_q[$];   // FIFO contents, head at [0]
  logic [0:0]    exp_q[$];    // expected line level per cycle of the frame in flight
  logic [DB-1:0] sent_q[$];   // bytes the model expects to be popped, in order
  int            pop_cycles[$];
  int            cycle  = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fif.fifo_empty = (fifo_q.size() == 0);
    fif.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : DB'($urandom);
  endtask

  task automatic push_byte(input logic [DB-1:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  // expected waveform of one frame: start, data LSB first, [parity], stop
  task automatic push_frame(input logic [DB-1:0] b);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++)
      for (int k = 0; k < CPB; k++) exp_q.push_back(b[i]);
    if (PAR != 0)
      for (int k = 0; k < CPB; k++) exp_q.push_back(^b);
    for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
  endtask

  // one clock: check outputs at negedge, let the FIFO react to the pop after posedge
  task automatic step();
    logic exp_ren;
    logic got_ren;
    @(negedge clk);
    exp_ren = !reset && (fifo_q.size() != 0) && (exp_q.size() == 0);
    got_ren = fif.fifo_r_en;
    check("r_en", got_ren, exp_ren);
    if (exp_q.size() != 0) begin
      check("tx", tx, exp_q.pop_front());
      check("busy", busy, 1);
    end else begin
      check("tx_idle", tx, 1);
      check("busy_idle", busy, 0);
      check("state_idle", state_dbg, ST_IDLE);
    end
    if (reset) exp_q.delete();
    if (exp_ren) begin
      push_frame(fifo_q[0]);
      sent_q.push_back(fifo_q[0]);
      pop_cycles.push_back(cycle);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (got_ren && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    check("drain_timeout", n < 3000, 1);
    step();
  endtask

  initial begin
    int base;
    int n;
    logic [DB-1:0] b;

    // 1: reset held with a non-empty FIFO -> no pop
    reset = 1'b1;
    push_byte(8'h11);
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < 3; i++) step();
    check("reset_no_pop", fifo_q.size(), 1);
    reset = 1'b0;
    drain();
    check("first_byte", sent_q[0], 8'h11);

    // 2: single 0xA5 after an empty spell
    for (int i = 0; i < 5; i++) step();
    base = pop_cycles.size();
    push_byte(8'hA5);
    drain();
    check("a5_pops", pop_cycles.size() - base, 1);

    // 3: back-to-back 0x00, 0xFF
    base = pop_cycles.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    drain();
    check("b2b_pops", pop_cycles.size() - base, 2);
    if (pop_cycles.size() - base == 2)
      check("b2b_period", pop_cycles[base+1] - pop_cycles[base], FRAME);

    // 4: empty FIFO for 100 cycles
    base = pop_cycles.size();
    for (int i = 0; i < 100; i++) step();
    check("empty_no_pop", pop_cycles.size() - base, 0);

    // 5: reset during data bit 3 of 0x3C, next frame carries 0x5E
    base = pop_cycles.size();
    push_byte(8'h3C);
    push_byte(8'h5E);
    n = 0;
    while (pop_cycles.size() == base && n < 100) begin
      step();
      n++;
    end
    check("pop_timeout", n < 100, 1);
    for (int i = 0; i < CPB + 3 * CPB + 1; i++) step();
    check("state_data", state_dbg, ST_DATA);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drain();
    check("abort_pops", pop_cycles.size() - base, 2);
    check("abort_next", sent_q[sent_q.size()-1], 8'h5E);

    // 6: parity patterns 0x07 (odd count) and 0x03 (even count)
    base = pop_cycles.size();
    push_byte(8'h07);
    push_byte(8'h03);
    drain();
    check("par_pops", pop_cycles.size() - base, 2);
    if (pop_cycles.size() - base == 2)
      check("par_period", pop_cycles[base+1] - pop_cycles[base], FRAME);

    // random traffic with occasional resets
    for (int r = 0; r < 40; r++) begin
      b = DB'($urandom);
      push_byte(b);
      if ($urandom_range(0, 2) == 0) push_byte(DB'($urandom));
      n = $urandom_range(0, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 99) == 0) reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
